// File: rtl/vend_pkg.sv
// Shared types and default pricing for the vending sequencer and its display logic.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DISP    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  localparam int unsigned VEND_VALUE_W   = 8;
  localparam int unsigned VEND_PRICE     = 25;
  localparam int unsigned VEND_COIN_UNIT = 5;

endpackage

// File: rtl/vend_timer.sv
// Loadable/clearable down-counter; done_o is high whenever the count is zero.
module vend_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;

  // Load wins over clear so a restart in the same cycle as leaving is not lost.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/vend_sequencer.sv
// Coin accumulation, dispense and coin-by-coin change payout controller.
// Optional inactivity refund in COLLECT when VEND_TIMEOUT_EN is defined.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int unsigned VALUE_W        = VEND_VALUE_W,
  parameter int unsigned PRICE          = VEND_PRICE,
  parameter int unsigned COIN_UNIT      = VEND_COIN_UNIT,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               coin_valid_i,
  input  logic [VALUE_W-1:0] coin_value_i,
  input  logic               cancel_i,
  input  logic               change_ack_i,
  output logic               dispense_o,
  output logic               change_req_o,
  output logic               coin_reject_o,
  output logic [VALUE_W-1:0] total_o,
  output logic               busy_o
);

  localparam logic [VALUE_W-1:0] PRICE_V = VALUE_W'(PRICE);
  localparam logic [VALUE_W-1:0] UNIT_V  = VALUE_W'(COIN_UNIT);

  state_t             state_q, state_d;
  logic [VALUE_W-1:0] total_q, total_d;
  logic               reject_q;
  logic               coin_accept;
  logic               timeout_hit;
  logic               req;
  logic [VALUE_W:0]   coin_sum;

  // Carry bit flags a sum that would not fit the total register.
  assign coin_sum = {1'b0, total_q} + {1'b0, coin_value_i};
  assign req      = (state_q == CHANGE) && (total_q >= UNIT_V);

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic tmr_done;

  vend_timer #(
    .CNT_W(TMR_W)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (coin_accept),
    .load_val_i(TMR_W'(TIMEOUT_CYCLES - 1)),
    .clr_i     (state_q != COLLECT),
    .en_i      (state_q == COLLECT),
    .done_o    (tmr_done)
  );

  assign timeout_hit = tmr_done;
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    coin_accept = 1'b0;
    case (state_q)
      IDLE: begin
        if (coin_valid_i) begin
          coin_accept = 1'b1;
          total_d     = coin_value_i;
          state_d     = COLLECT;
        end
      end
      COLLECT: begin
        // A coin arriving with cancel/timeout or once the price is met is refused.
        if (cancel_i || timeout_hit) begin
          state_d = CHANGE;
        end else if (total_q >= PRICE_V) begin
          state_d = DISP;
        end else if (coin_valid_i && !coin_sum[VALUE_W]) begin
          coin_accept = 1'b1;
          total_d     = coin_sum[VALUE_W-1:0];
        end
      end
      DISP: begin
        total_d = total_q - PRICE_V;
        state_d = CHANGE;
      end
      CHANGE: begin
        if (!req) begin
          total_d = '0;
          state_d = IDLE;
        end else if (change_ack_i) begin
          total_d = total_q - UNIT_V;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      total_q  <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      total_q  <= total_d;
      reject_q <= coin_valid_i && !coin_accept;
    end
  end

  assign dispense_o    = (state_q == DISP);
  assign change_req_o  = req;
  assign coin_reject_o = reject_q;
  assign total_o       = total_q;
  assign busy_o        = (state_q == DISP) || (state_q == CHANGE);

endmodule

// File: tb/tb_vend_sequencer.sv
// Table-driven scoreboard bench for vend_sequencer (PRICE 25, COIN_UNIT 5, timeout 16).
module tb_vend_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       coin_valid_i = 1'b0;
  logic [7:0] coin_value_i = '0;
  logic       cancel_i = 1'b0;
  logic       change_ack_i = 1'b0;
  logic       dispense_o, change_req_o, coin_reject_o, busy_o;
  logic [7:0] total_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       d;
    logic       r;
    logic       j;
    logic       b;
    logic [7:0] tot;
  } out_t;

  typedef struct {
    logic       rst;
    logic       cv;
    logic [7:0] val;
    logic       can;
    logic       ack;
    out_t       exp;
    string      nm;
  } vec_t;

  typedef struct {
    out_t  exp;
    string nm;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];

  vend_sequencer #(
    .VALUE_W       (8),
    .PRICE         (25),
    .COIN_UNIT     (5),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .coin_valid_i (coin_valid_i),
    .coin_value_i (coin_value_i),
    .cancel_i     (cancel_i),
    .change_ack_i (change_ack_i),
    .dispense_o   (dispense_o),
    .change_req_o (change_req_o),
    .coin_reject_o(coin_reject_o),
    .total_o      (total_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic add(input logic rst, cv, input int val, input logic can, ack,
                     input logic d, r, j, b, input int tot, input string nm);
    vec_t v;
    v.rst = rst; v.cv = cv; v.val = 8'(val); v.can = can; v.ack = ack;
    v.exp = '{d: d, r: r, j: j, b: b, tot: 8'(tot)};
    v.nm  = nm;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_pop();
    sb_t  e;
    out_t a;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: output with no expected entry");
      return;
    end
    e = sb_q.pop_front();
    a = '{d: dispense_o, r: change_req_o, j: coin_reject_o, b: busy_o, tot: total_o};
    checks++;
    if (a !== e.exp) begin
      errors++;
      $display("FAIL %s: got d=%b r=%b j=%b b=%b tot=%0d expected d=%b r=%b j=%b b=%b tot=%0d",
               e.nm, a.d, a.r, a.j, a.b, a.tot, e.exp.d, e.exp.r, e.exp.j, e.exp.b, e.exp.tot);
    end
  endtask

  task automatic apply(input vec_t v);
    sb_t e;
    @(negedge clk_i);
    rst_i = v.rst; coin_valid_i = v.cv; coin_value_i = v.val;
    cancel_i = v.can; change_ack_i = v.ack;
    e.exp = v.exp; e.nm = v.nm;
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    check_pop();
  endtask

  task automatic step(input logic cv, input int val, input logic can, ack,
                      input logic d, r, j, b, input int tot, input string nm);
    vec_t v;
    v.rst = 1'b0; v.cv = cv; v.val = 8'(val); v.can = can; v.ack = ack;
    v.exp = '{d: d, r: r, j: j, b: b, tot: 8'(tot)};
    v.nm  = nm;
    apply(v);
  endtask

  initial begin
    int pays;
    int cyc;

    //   rst cv val can ack | d r j b tot
    add(1, 0,   0, 0, 0,  0, 0, 0, 0,  0, "reset0");
    add(1, 1,  10, 1, 1,  0, 0, 0, 0,  0, "reset1");
    add(0, 0,   0, 1, 1,  0, 0, 0, 0,  0, "idle_cancel");
    // 10,10,10 with ack high: dispense then one change coin
    add(0, 1,  10, 0, 1,  0, 0, 0, 0, 10, "A_c1");
    add(0, 1,  10, 0, 1,  0, 0, 0, 0, 20, "A_c2");
    add(0, 1,  10, 0, 1,  0, 0, 0, 0, 30, "A_c3");
    add(0, 0,   0, 0, 1,  1, 0, 0, 1, 30, "A_disp");
    add(0, 0,   0, 0, 1,  0, 1, 0, 1,  5, "A_req");
    add(0, 0,   0, 0, 1,  0, 0, 0, 1,  0, "A_paid");
    add(0, 0,   0, 0, 1,  0, 0, 0, 0,  0, "A_idle");
    // 20,5: exact price, no change
    add(0, 1,  20, 0, 0,  0, 0, 0, 0, 20, "B_c1");
    add(0, 1,   5, 0, 0,  0, 0, 0, 0, 25, "B_c2");
    add(0, 0,   0, 0, 0,  1, 0, 0, 1, 25, "B_disp");
    add(0, 0,   0, 0, 0,  0, 0, 0, 1,  0, "B_chg");
    add(0, 0,   0, 0, 0,  0, 0, 0, 0,  0, "B_idle");
    // 10,5, cancel, ack stalled 4 cycles
    add(0, 1,  10, 0, 0,  0, 0, 0, 0, 10, "C_c1");
    add(0, 1,   5, 0, 0,  0, 0, 0, 0, 15, "C_c2");
    add(0, 0,   0, 1, 0,  0, 1, 0, 1, 15, "C_cancel");
    add(0, 0,   0, 0, 0,  0, 1, 0, 1, 15, "C_stall1");
    add(0, 0,   0, 0, 0,  0, 1, 0, 1, 15, "C_stall2");
    add(0, 0,   0, 0, 0,  0, 1, 0, 1, 15, "C_stall3");
    add(0, 0,   0, 0, 0,  0, 1, 0, 1, 15, "C_stall4");
    add(0, 0,   0, 0, 1,  0, 1, 0, 1, 10, "C_pay1");
    add(0, 0,   0, 0, 1,  0, 1, 0, 1,  5, "C_pay2");
    add(0, 0,   0, 0, 1,  0, 0, 0, 1,  0, "C_pay3");
    add(0, 0,   0, 0, 1,  0, 0, 0, 0,  0, "C_idle");
    add(0, 0,   0, 0, 1,  0, 0, 0, 0,  0, "C_idle_ack");
    // 20,7: remainder 2 forfeited
    add(0, 1,  20, 0, 1,  0, 0, 0, 0, 20, "D_c1");
    add(0, 1,   7, 0, 1,  0, 0, 0, 0, 27, "D_c2");
    add(0, 0,   0, 0, 1,  1, 0, 0, 1, 27, "D_disp");
    add(0, 0,   0, 0, 1,  0, 0, 0, 1,  2, "D_rem");
    add(0, 0,   0, 0, 1,  0, 0, 0, 0,  0, "D_idle");
    // overflow rejects at total 20, then refund
    add(0, 1,  20, 0, 1,  0, 0, 0, 0, 20, "R_c1");
    add(0, 1, 250, 0, 1,  0, 0, 1, 0, 20, "R_rej250");
    add(0, 1, 236, 0, 1,  0, 0, 1, 0, 20, "R_rej236");
    add(0, 0,   0, 1, 1,  0, 1, 0, 1, 20, "R_cancel");
    add(0, 0,   0, 0, 1,  0, 1, 0, 1, 15, "R_pay1");
    add(0, 0,   0, 0, 1,  0, 1, 0, 1, 10, "R_pay2");
    add(0, 0,   0, 0, 1,  0, 1, 0, 1,  5, "R_pay3");
    add(0, 0,   0, 0, 1,  0, 0, 0, 1,  0, "R_pay4");
    add(0, 0,   0, 0, 1,  0, 0, 0, 0,  0, "R_idle");
    // cancel with coin, then coin during CHANGE
    add(0, 1,  10, 0, 0,  0, 0, 0, 0, 10, "E_c1");
    add(0, 1,   5, 1, 0,  0, 1, 1, 1, 10, "E_cancel_coin");
    add(0, 1,   5, 0, 0,  0, 1, 1, 1, 10, "E_chg_coin");
    add(0, 0,   0, 0, 1,  0, 1, 0, 1,  5, "E_pay1");
    add(0, 0,   0, 0, 1,  0, 0, 0, 1,  0, "E_pay2");
    add(0, 0,   0, 0, 1,  0, 0, 0, 0,  0, "E_idle");
    // exact price from IDLE, coins refused at price and in DISP
    add(0, 1,  25, 0, 0,  0, 0, 0, 0, 25, "F_c1");
    add(0, 1,   5, 0, 0,  1, 0, 1, 1, 25, "F_full_coin");
    add(0, 1,   5, 0, 0,  0, 0, 1, 1,  0, "F_disp_coin");
    add(0, 0,   0, 0, 0,  0, 0, 0, 0,  0, "F_idle");
    // reset mid-CHANGE, no payout resumes
    add(0, 1,  10, 0, 0,  0, 0, 0, 0, 10, "S_c1");
    add(0, 0,   0, 1, 0,  0, 1, 0, 1, 10, "S_cancel");
    add(1, 0,   0, 0, 0,  0, 0, 0, 0,  0, "S_reset");
    add(0, 0,   0, 0, 1,  0, 0, 0, 0,  0, "S_after1");
    add(0, 0,   0, 0, 1,  0, 0, 0, 0,  0, "S_after2");

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Largest legal total: 20 + 235 = 255, giving 46 change coins
    step(1,  20, 0, 0,  0, 0, 0, 0,  20, "M_c1");
    step(1, 235, 0, 0,  0, 0, 0, 0, 255, "M_c2");
    step(0,   0, 0, 0,  1, 0, 0, 1, 255, "M_disp");
    step(0,   0, 0, 0,  0, 1, 0, 1, 230, "M_chg");
    pays = 0;
    cyc  = 0;
    while (busy_o && cyc < 100) begin
      @(negedge clk_i);
      change_ack_i = 1'b1;
      if (change_req_o) pays++;
      @(posedge clk_i);
      #1;
      cyc++;
    end
    chk("M_payouts", pays, 46);
    chk("M_total", total_o, 0);
    chk("M_idle", busy_o, 0);

    // Inactivity behaviour after a single coin
    step(1, 10, 0, 0,  0, 0, 0, 0, 10, "T_c1");
`ifdef VEND_TIMEOUT_EN
    for (int i = 0; i < 15; i++) step(0, 0, 0, 0,  0, 0, 0, 0, 10, "T_wait");
    step(0, 0, 0, 0,  0, 1, 0, 1, 10, "T_expire");
`else
    for (int i = 0; i < 1000; i++) step(0, 0, 0, 0,  0, 0, 0, 0, 10, "T_hold");
    step(0, 0, 1, 0,  0, 1, 0, 1, 10, "T_cancel");
`endif
    step(0, 0, 0, 1,  0, 1, 0, 1,  5, "T_pay1");
    step(0, 0, 0, 1,  0, 0, 0, 1,  0, "T_pay2");
    step(0, 0, 0, 1,  0, 0, 0, 0,  0, "T_idle");

    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
